l15_req_arbiter: RTL and testbench
==================================

L15_REQ_ARBITER -- requirements
Module: l15_req_arbiter

Interface
REQ-001 SHALL have parameter AddrWidth, default 64: width of all address fields.
REQ-002 SHALL have parameter DataWidth, default 64: store data width.
REQ-003 SHALL have parameter MaxOutstandingStores, default 7: cap on unacknowledged stores at L1.5.
REQ-004 SHALL have a single clock and an asynchronous, active-low reset (clk_i, rst_ni); ports follow.
REQ-005 clk_i  in  1  clock; all state rising-edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 icache_req_i  in  1, icache_addr_i  in  AddrWidth, icache_gnt_o  out  1: instruction fill requester.
REQ-008 dload_req_i  in  1, dload_addr_i  in  AddrWidth, dload_gnt_o  out  1: dcache load-miss requester.
REQ-009 dstore_req_i  in  1, dstore_addr_i  in  AddrWidth, dstore_data_i  in  DataWidth, dstore_gnt_o  out  1: write-through store requester.
REQ-010 l15_val_o  out  1, l15_ack_i  in  1: L1.5 request handshake.
REQ-011 l15_rqtype_o  out  2 (0 ifill, 1 load, 2 store), l15_addr_o  out  AddrWidth, l15_data_o  out  DataWidth: registered request payload.
REQ-012 store_ack_i  in  1: one-cycle pulse per store completed by L1.5.
REQ-013 stores_pending_o  out  $clog2(MaxOutstandingStores+1)  current outstanding store count.

Function
REQ-014 SHALL implement FSM IDLE/BUSY.
REQ-015 IDLE: if any eligible request, select one winner, register its type/address/data, pulse its gnt_o for exactly that cycle, go BUSY next cycle; else stay IDLE.
REQ-016 BUSY: l15_val_o=1, payload stable; on l15_ack_i=1 go IDLE next cycle (one bubble cycle between requests).
REQ-017 l15_val_o SHALL be 0 in IDLE; at most one gnt_o high per cycle; no gnt_o in BUSY.
REQ-018 Requesters hold req and payload until gnt; gnt without req SHALL never occur.
REQ-019 Store eligible only when stores_pending_o < MaxOutstandingStores; blocked stores do not block other requesters.
REQ-020 Counter +1 on store grant, -1 on store_ack_i; both same cycle -> unchanged.
REQ-021 store_ack_i at count 0 SHALL leave count 0 (saturate) and fire a simulation assertion.
REQ-022 l15_data_o SHALL be 0 for ifill and load requests.
REQ-023 l15_ack_i in IDLE SHALL be ignored.

Reset
REQ-024 On rst_ni=0, asynchronously: FSM IDLE, l15_val_o=0, all gnt_o=0, l15_rqtype_o=0, l15_addr_o=0, l15_data_o=0, stores_pending_o=0, round-robin pointer to icache.
REQ-025 Reset mid-BUSY SHALL abandon the in-flight request; no gnt or counter update on the reset cycle.

Configuration
REQ-026 Macro WT_L15_ARB_RR_EN defined: round-robin among eligible requesters, order icache->load->store; last winner becomes lowest priority.
REQ-027 Macro undefined: fixed priority store > load > icache; pointer logic absent.

Verification
REQ-028 Single icache req addr 0x8000_0040 -> icache_gnt_o pulse cycle N, l15_val_o=1 rqtype=0 from N+1, held until ack, IDLE one cycle after ack.
REQ-029 Seven back-to-back stores, no store_ack_i -> stores_pending_o=7, 8th store held without gnt while a concurrent load is granted; one store_ack_i -> 8th store granted.
REQ-030 Store grant and store_ack_i same cycle at count 3 -> count stays 3.
REQ-031 All three requesting continuously, macro undefined -> grant order store,store,...; macro defined -> icache,load,store,icache repeating.
REQ-032 store_ack_i at count 0 -> count stays 0, assertion fires.
REQ-033 rst_ni low during BUSY with l15_val_o=1 -> l15_val_o=0 and count 0 immediately; first post-reset request granted normally.

Source files
------------

// File: rtl/l15_req_arbiter.sv
// l15_req_arbiter: arbitrates instruction-fill, load-miss and write-through store
// requests onto a single L1.5 request channel.
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   icache_req_i/_addr_i, icache_gnt_o  instruction fill requester
//   dload_req_i/_addr_i, dload_gnt_o    dcache load-miss requester
//   dstore_req_i/_addr_i/_data_i, dstore_gnt_o  write-through store requester
//   l15_val_o, l15_ack_i                L1.5 request handshake
//   l15_rqtype_o/_addr_o/_data_o        registered request payload (0 ifill, 1 load, 2 store)
//   store_ack_i                         one pulse per store completed by L1.5
//   stores_pending_o                    outstanding store count
// Define WT_L15_ARB_RR_EN for round-robin arbitration (icache->load->store, last
// winner lowest); otherwise fixed priority store > load > icache.
module l15_req_arbiter #(
    parameter int AddrWidth            = 64,
    parameter int DataWidth            = 64,
    parameter int MaxOutstandingStores = 7,
    localparam int CntWidth            = $clog2(MaxOutstandingStores + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 icache_req_i,
    input  logic [AddrWidth-1:0] icache_addr_i,
    output logic                 icache_gnt_o,
    input  logic                 dload_req_i,
    input  logic [AddrWidth-1:0] dload_addr_i,
    output logic                 dload_gnt_o,
    input  logic                 dstore_req_i,
    input  logic [AddrWidth-1:0] dstore_addr_i,
    input  logic [DataWidth-1:0] dstore_data_i,
    output logic                 dstore_gnt_o,
    output logic                 l15_val_o,
    input  logic                 l15_ack_i,
    output logic [1:0]           l15_rqtype_o,
    output logic [AddrWidth-1:0] l15_addr_o,
    output logic [DataWidth-1:0] l15_data_o,
    input  logic                 store_ack_i,
    output logic [CntWidth-1:0]  stores_pending_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstandingStores);

    state_t     state, state_nxt;
    logic [2:0] elig, win;
    logic       go, inc, dec;

    // bit 0 icache, bit 1 load, bit 2 store; a full store window only masks the store
    assign elig = {dstore_req_i && stores_pending_o < CntMax, dload_req_i, icache_req_i};
    assign go   = state == IDLE && |elig;

`ifdef WT_L15_ARB_RR_EN
    logic [1:0] ptr;
    logic [2:0] rot, pick;

    // rotate so the pointed-to requester sits at bit 0, pick lowest, rotate back
    always_comb begin
        rot  = ptr == 2'd1 ? {elig[0], elig[2], elig[1]} :
               ptr == 2'd2 ? {elig[1], elig[0], elig[2]} : elig;
        pick = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
        win  = ptr == 2'd1 ? {pick[1], pick[0], pick[2]} :
               ptr == 2'd2 ? {pick[0], pick[2], pick[1]} : pick;
    end

    // pointer moves to the requester after the winner
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) ptr <= 2'd0;
        else if (go) ptr <= win[0] ? 2'd1 : win[1] ? 2'd2 : 2'd0;
`else
    assign win = elig[2] ? 3'b100 : elig[1] ? 3'b010 : elig[0] ? 3'b001 : 3'b000;
`endif

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state <= IDLE;
        else state <= state_nxt;

    always_comb
        state_nxt = state == IDLE ? (go ? BUSY : IDLE) : (l15_ack_i ? IDLE : BUSY);

    // grants are gated by rst_ni so none can appear while reset is asserted
    always_comb begin
        l15_val_o = state == BUSY;
        {dstore_gnt_o, dload_gnt_o, icache_gnt_o} = win & {3{go && rst_ni}};
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            l15_rqtype_o <= 2'd0;
            l15_addr_o   <= '0;
            l15_data_o   <= '0;
        end else if (go) begin
            l15_rqtype_o <= win[2] ? 2'd2 : win[1] ? 2'd1 : 2'd0;
            l15_addr_o   <= win[2] ? dstore_addr_i : win[1] ? dload_addr_i : icache_addr_i;
            l15_data_o   <= win[2] ? dstore_data_i : '0;
        end

    // an ack with nothing outstanding is dropped rather than wrapping the count
    assign inc = go && win[2];
    assign dec = store_ack_i && stores_pending_o != '0;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) stores_pending_o <= '0;
        else stores_pending_o <= stores_pending_o + CntWidth'(inc) - CntWidth'(dec);

    always @(posedge clk_i)
        if (rst_ni)
            assert (!(store_ack_i && stores_pending_o == '0))
            else $warning("store_ack_i received with no stores pending");
endmodule

// File: tb/tb_l15_req_arbiter.sv
// tb_l15_req_arbiter: table-driven, directed and randomized checks of l15_req_arbiter.
module tb_l15_req_arbiter;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int MAX = 7;
    localparam int CW  = $clog2(MAX + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          icache_req_i = 1'b0, dload_req_i = 1'b0, dstore_req_i = 1'b0;
    logic          l15_ack_i = 1'b0, store_ack_i = 1'b0;
    logic [AW-1:0] icache_addr_i = '0, dload_addr_i = '0, dstore_addr_i = '0;
    logic [DW-1:0] dstore_data_i = '0;
    logic          icache_gnt_o, dload_gnt_o, dstore_gnt_o, l15_val_o;
    logic [1:0]    l15_rqtype_o;
    logic [AW-1:0] l15_addr_o;
    logic [DW-1:0] l15_data_o;
    logic [CW-1:0] stores_pending_o;

    l15_req_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstandingStores(MAX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .icache_req_i(icache_req_i), .icache_addr_i(icache_addr_i), .icache_gnt_o(icache_gnt_o),
        .dload_req_i(dload_req_i), .dload_addr_i(dload_addr_i), .dload_gnt_o(dload_gnt_o),
        .dstore_req_i(dstore_req_i), .dstore_addr_i(dstore_addr_i), .dstore_data_i(dstore_data_i),
        .dstore_gnt_o(dstore_gnt_o),
        .l15_val_o(l15_val_o), .l15_ack_i(l15_ack_i),
        .l15_rqtype_o(l15_rqtype_o), .l15_addr_o(l15_addr_o), .l15_data_o(l15_data_o),
        .store_ack_i(store_ack_i), .stores_pending_o(stores_pending_o)
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nfail = 0;

    // reference model state: what the arbiter should hold after the last edge
    int          m_busy, m_cnt, m_last;
    logic [1:0]  m_type;
    logic [63:0] m_addr, m_data;

    // expected and actual values for the cycle just sampled
    logic [2:0]  e_gnt, a_gnt;
    logic        e_val, a_val;
    logic [1:0]  e_type, a_type;
    logic [63:0] e_addr, a_addr, e_data, a_data;
    int          e_cnt, a_cnt;

    typedef struct {
        logic       ic, ld, st, ack, sack;
        logic [2:0] gnt;
        logic       val;
        logic [1:0] rqtype;
        int         cnt;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_cnt  = 0;
        m_last = 2;   // next search starts at icache
        m_type = 2'd0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Called at posedge+1: drive inputs, sample at the falling edge, advance model,
    // return at the next posedge+1.
    task automatic cyc(input logic ic, input logic ld, input logic st, input logic ack, input logic sack);
        logic [2:0] el;
        int         w, j;
        icache_req_i = ic;
        dload_req_i  = ld;
        dstore_req_i = st;
        l15_ack_i    = ack;
        store_ack_i  = sack;
        #4;
        el = {st && m_cnt < MAX, ld, ic};
        w  = -1;
        if (m_busy == 0) begin
`ifdef WT_L15_ARB_RR_EN
            for (int k = 1; k <= 3; k++) begin
                j = (m_last + k) % 3;
                if (w < 0 && ((el >> j) & 3'd1) != 3'd0) w = j;
            end
`else
            for (int k = 2; k >= 0; k--)
                if (w < 0 && ((el >> k) & 3'd1) != 3'd0) w = k;
`endif
        end
        e_gnt  = w < 0 ? 3'b000 : 3'(1 << w);
        e_val  = m_busy != 0;
        e_type = m_type;
        e_addr = m_addr;
        e_data = m_data;
        e_cnt  = m_cnt;
        a_gnt  = {dstore_gnt_o, dload_gnt_o, icache_gnt_o};
        a_val  = l15_val_o;
        a_type = l15_rqtype_o;
        a_addr = l15_addr_o;
        a_data = l15_data_o;
        a_cnt  = int'(stores_pending_o);
        if (w >= 0) begin
            m_busy = 1;
            m_last = w;
            m_type = 2'(w);
            m_addr = w == 2 ? dstore_addr_i : w == 1 ? dload_addr_i : icache_addr_i;
            m_data = w == 2 ? dstore_data_i : '0;
        end else if (m_busy != 0 && ack) begin
            m_busy = 0;
        end
        m_cnt = m_cnt + (w == 2 ? 1 : 0) - ((sack && m_cnt > 0) ? 1 : 0);
        @(posedge clk_i);
        #1;
    endtask

    task automatic cmp_model();
        check("rnd_gnt", a_gnt, e_gnt);
        check("rnd_val", a_val, e_val);
        check("rnd_cnt", a_cnt, e_cnt);
        if (e_val) begin
            check("rnd_type", a_type, e_type);
            check("rnd_addr", a_addr, e_addr);
            check("rnd_data", a_data, e_data);
        end
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        icache_req_i = 1'b0;
        dload_req_i  = 1'b0;
        dstore_req_i = 1'b0;
        l15_ack_i    = 1'b0;
        store_ack_i  = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [2:0] order[4];
        logic       ri, rl, rs, ack, sack;

        tbl[0]  = '{0, 0, 0, 0, 0, 3'b000, 0, 2'd0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 3'b001, 0, 2'd0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 3'b000, 1, 2'd0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 3'b000, 1, 2'd0, 0};
        tbl[4]  = '{0, 0, 0, 1, 0, 3'b000, 1, 2'd0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 3'b000, 0, 2'd0, 0};
        tbl[6]  = '{0, 1, 0, 1, 0, 3'b010, 0, 2'd0, 0};
        tbl[7]  = '{0, 0, 0, 1, 0, 3'b000, 1, 2'd1, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 3'b000, 0, 2'd1, 0};
        tbl[9]  = '{0, 0, 1, 0, 0, 3'b100, 0, 2'd1, 0};
        tbl[10] = '{0, 0, 0, 1, 0, 3'b000, 1, 2'd2, 1};
        tbl[11] = '{0, 0, 0, 0, 1, 3'b000, 0, 2'd2, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 3'b000, 0, 2'd2, 0};
        tbl[13] = '{1, 0, 0, 1, 0, 3'b001, 0, 2'd2, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 3'b000, 1, 2'd0, 0};
        tbl[15] = '{0, 0, 0, 1, 0, 3'b000, 1, 2'd0, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 3'b000, 0, 2'd0, 0};

        // reset state while rst_ni is held low
        #2;
        check("rst_val", l15_val_o, 1'b0);
        check("rst_gnt", {dstore_gnt_o, dload_gnt_o, icache_gnt_o}, 3'b000);
        check("rst_cnt", stores_pending_o, 0);
        check("rst_addr", l15_addr_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();

        icache_addr_i = 64'h0000_0000_8000_0040;
        dload_addr_i  = 64'h0000_0000_0000_1000;
        dstore_addr_i = 64'h0000_0000_0000_2008;
        dstore_data_i = 64'hDEAD_BEEF_0123_4567;
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].ic, tbl[i].ld, tbl[i].st, tbl[i].ack, tbl[i].sack);
            check($sformatf("tbl%0d_gnt", i), a_gnt, tbl[i].gnt);
            check($sformatf("tbl%0d_val", i), a_val, tbl[i].val);
            check($sformatf("tbl%0d_type", i), a_type, tbl[i].rqtype);
            check($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].cnt);
            if (i == 2) check("ifill_addr", a_addr, 64'h0000_0000_8000_0040);
            if (i == 7) check("load_data_zero", a_data, 64'h0);
            if (i == 10) check("store_data", a_data, 64'hDEAD_BEEF_0123_4567);
        end

        // seven stores fill the window; the eighth waits while a load goes through
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 1, 0, 0);
            check("fill_store_gnt", a_gnt, 3'b100);
            cyc(0, 0, 0, 1, 0);
        end
        cyc(0, 1, 1, 0, 0);
        check("full_load_gnt", a_gnt, 3'b010);
        check("full_cnt7", a_cnt, 7);
        cyc(0, 0, 1, 1, 0);
        check("full_busy_no_gnt", a_gnt, 3'b000);
        cyc(0, 0, 1, 0, 1);
        check("full_store_held", a_gnt, 3'b000);
        check("full_cnt_before_ack", a_cnt, 7);
        cyc(0, 0, 1, 0, 0);
        check("store8_gnt", a_gnt, 3'b100);
        check("cnt_after_ack", a_cnt, 6);
        cyc(0, 0, 0, 1, 0);
        check("cnt_after_store8", a_cnt, 7);

        // grant and ack in the same cycle at count 3
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 1, 0);
        end
        cyc(0, 0, 1, 0, 1);
        check("same_cyc_gnt", a_gnt, 3'b100);
        check("same_cyc_cnt_before", a_cnt, 3);
        cyc(0, 0, 0, 1, 0);
        check("same_cyc_cnt_after", a_cnt, 3);

        // ack with nothing outstanding saturates at zero
        do_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check("sat_cnt0", a_cnt, 0);

        // all three requesting continuously
`ifdef WT_L15_ARB_RR_EN
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        order = '{3'b100, 3'b100, 3'b100, 3'b100};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 0, 0);
            check($sformatf("order%0d", i), a_gnt, order[i]);
            cyc(1, 1, 1, 1, 0);
            check("order_busy_no_gnt", a_gnt, 3'b000);
        end

        // reset while a store is in flight
        do_reset();
        cyc(0, 0, 1, 0, 0);
        icache_req_i = 1'b1;
        dload_req_i  = 1'b1;
        #1;
        check("pre_rst_val", l15_val_o, 1'b1);
        check("pre_rst_cnt", stores_pending_o, 1);
        rst_ni = 1'b0;
        #1;
        check("midrst_val", l15_val_o, 1'b0);
        check("midrst_cnt", stores_pending_o, 0);
        check("midrst_gnt", {dstore_gnt_o, dload_gnt_o, icache_gnt_o}, 3'b000);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
        cyc(0, 1, 0, 0, 0);
        check("post_rst_gnt", a_gnt, 3'b010);
        cyc(0, 0, 0, 0, 0);
        check("post_rst_val", a_val, 1'b1);
        check("post_rst_type", a_type, 2'd1);
        check("post_rst_addr", a_addr, 64'h0000_0000_0000_1000);

        // randomized traffic against the model
        do_reset();
        ri = 1'b0;
        rl = 1'b0;
        rs = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!ri && $urandom_range(0, 99) < 40) begin
                ri = 1'b1;
                icache_addr_i = {$urandom, $urandom};
            end
            if (!rl && $urandom_range(0, 99) < 40) begin
                rl = 1'b1;
                dload_addr_i = {$urandom, $urandom};
            end
            if (!rs && $urandom_range(0, 99) < 50) begin
                rs = 1'b1;
                dstore_addr_i = {$urandom, $urandom};
                dstore_data_i = {$urandom, $urandom};
            end
            ack  = m_busy != 0 ? $urandom_range(0, 99) < 35 : $urandom_range(0, 99) < 10;
            sack = m_cnt > 0 && $urandom_range(0, 99) < 15;
            cyc(ri, rl, rs, ack, sack);
            cmp_model();
            if (e_gnt[0]) ri = 1'b0;
            if (e_gnt[1]) rl = 1'b0;
            if (e_gnt[2]) rs = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
